seq_detector_hamming_param: RTL and testbench

//   Parametrised serial pattern detector. A WIDTH-bit shift register compares each new window

---
 rtl/seq_detector_hamming_param.sv | 110 +++++++++++
 tb/tb_seq_detector_hamming_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_hamming_param.sv
// Serial pattern detector: flags any WIDTH-bit window within a programmable Hamming
// distance of PATTERN, with runtime overlap control and a saturating hit counter.
module seq_detector_hamming_param #(
    parameter int                WIDTH   = 6,
    parameter logic [WIDTH-1:0]  PATTERN = 6'b101001,
    parameter int                MAX_ERR = 2,
    parameter int                CNT_W   = 8,
    localparam int               ERR_W   = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_valid,
    input  logic             i_data,
    input  logic             i_overlap,
    input  logic [ERR_W-1:0] i_tol,
    input  logic             i_clr_cnt,
    output logic             o_pattern_found,
    output logic             o_exact,
    output logic [ERR_W-1:0] o_err_dist,
    output logic [CNT_W-1:0] o_hit_count
);

    generate
        if (WIDTH < 2) begin : g_badWidth
            $error("seq_detector_hamming_param: WIDTH must be at least 2");
        end
        if (MAX_ERR >= WIDTH) begin : g_badMaxErr
            $error("seq_detector_hamming_param: MAX_ERR must be smaller than WIDTH");
        end
    endgenerate

    localparam logic [ERR_W-1:0] MAX_ERR_C = ERR_W'(MAX_ERR);
    localparam logic [ERR_W-1:0] FILL_FULL = ERR_W'(WIDTH);
    localparam logic [ERR_W-1:0] FILL_LAST = ERR_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [WIDTH-1:0] r_shiftReg;
    logic [ERR_W-1:0] r_fill;
    logic             r_found;
    logic             r_exact;
    logic [ERR_W-1:0] r_errDist;
    logic [CNT_W-1:0] r_hitCount;

    logic [WIDTH-1:0] w_window;
    logic [WIDTH-1:0] w_diff;
    logic [ERR_W-1:0] w_dist;
    logic [ERR_W-1:0] w_tolEff;
    logic             w_windowFull;
    logic             w_hit;

    // The window includes the bit arriving this cycle, so a hit is reported on the
    // same edge that samples the completing bit.
    assign w_window = {r_shiftReg[WIDTH-2:0], i_data};
    assign w_diff   = w_window ^ PATTERN;

    always_comb begin
        w_dist = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_dist = w_dist + ERR_W'(w_diff[k]);
        end
    end

    assign w_tolEff     = (i_tol > MAX_ERR_C) ? MAX_ERR_C : i_tol;
    assign w_windowFull = (r_fill >= FILL_LAST);
    assign w_hit        = i_valid & w_windowFull & (w_dist <= w_tolEff);

    // Clearing fill on a non-overlapping hit forces WIDTH fresh valid bits before the
    // next evaluation; the stale shift contents are shifted out before they matter.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_shiftReg <= '0;
            r_fill     <= '0;
            r_found    <= 1'b0;
            r_exact    <= 1'b0;
            r_errDist  <= '0;
        end else begin
            r_found <= w_hit;
            r_exact <= w_hit && (w_dist == '0);
            if (w_hit) begin
                r_errDist <= w_dist;
            end
            if (i_valid) begin
                r_shiftReg <= w_window;
                if (w_hit && !i_overlap) begin
                    r_fill <= '0;
                end else if (r_fill != FILL_FULL) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    // A clear coinciding with a hit keeps that hit, so the count restarts at one.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_hitCount <= '0;
        end else if (i_clr_cnt) begin
            r_hitCount <= w_hit ? CNT_ONE : '0;
        end else if (w_hit && (r_hitCount != CNT_MAX)) begin
            r_hitCount <= r_hitCount + 1'b1;
        end
    end

    assign o_pattern_found = r_found;
    assign o_exact         = r_exact;
    assign o_err_dist      = r_errDist;
    assign o_hit_count     = r_hitCount;

endmodule

// File: tb/tb_seq_detector_hamming_param.sv
// Self-checking bench for seq_detector_hamming_param: vector table, directed corner
// sequences and random traffic against a window-history reference model.
module tb_seq_detector_hamming_param;

    localparam int               WIDTH   = 6;
    localparam logic [WIDTH-1:0] PATTERN = 6'b101001;
    localparam int               MAX_ERR = 2;
    localparam int               ERR_W   = $clog2(WIDTH + 1);
    localparam int               CNT_A_W = 8;
    localparam int               CNT_B_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               resetn = 1'b0;
    logic               valid  = 1'b0;
    logic               data   = 1'b0;
    logic               ovl    = 1'b1;
    logic [ERR_W-1:0]   tol    = '0;
    logic               clr    = 1'b0;

    logic               foundA, exactA, foundB, exactB;
    logic [ERR_W-1:0]   distA, distB;
    logic [CNT_A_W-1:0] countA;
    logic [CNT_B_W-1:0] countB;

    seq_detector_hamming_param #(
        .WIDTH(WIDTH), .PATTERN(PATTERN), .MAX_ERR(MAX_ERR), .CNT_W(CNT_A_W)
    ) dutA (
        .i_clk(clk), .i_resetn(resetn), .i_valid(valid), .i_data(data),
        .i_overlap(ovl), .i_tol(tol), .i_clr_cnt(clr),
        .o_pattern_found(foundA), .o_exact(exactA), .o_err_dist(distA), .o_hit_count(countA)
    );

    seq_detector_hamming_param #(
        .WIDTH(WIDTH), .PATTERN(PATTERN), .MAX_ERR(MAX_ERR), .CNT_W(CNT_B_W)
    ) dutB (
        .i_clk(clk), .i_resetn(resetn), .i_valid(valid), .i_data(data),
        .i_overlap(ovl), .i_tol(tol), .i_clr_cnt(clr),
        .o_pattern_found(foundB), .o_exact(exactB), .o_err_dist(distB), .o_hit_count(countB)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the valid bits seen since the last reset or non-overlapping hit.
    bit histQ[$];
    bit mFound, mExact;
    int mDist, mCountA, mCountB;

    typedef struct {
        bit rstN; bit v; bit d; bit o; int t; bit c;
        bit eFound; bit eExact; int eDist; int eCount;
    } vec_t;
    vec_t vecs[$];

    task automatic addRow(input bit rstN, input bit v, input bit d, input bit o, input int t,
                          input bit c, input bit eFound, input bit eExact, input int eDist,
                          input int eCount);
        vec_t r;
        r.rstN = rstN; r.v = v; r.d = d; r.o = o; r.t = t; r.c = c;
        r.eFound = eFound; r.eExact = eExact; r.eDist = eDist; r.eCount = eCount;
        vecs.push_back(r);
    endtask

    task automatic modelStep();
        logic [WIDTH-1:0] patVec;
        bit hit;
        int d, tolEff;
        patVec = PATTERN;
        hit = 1'b0;
        d = 0;
        if (!resetn) begin
            histQ.delete();
            mFound = 0; mExact = 0; mDist = 0; mCountA = 0; mCountB = 0;
            return;
        end
        if (valid) begin
            histQ.push_back(data);
            if (histQ.size() > WIDTH) void'(histQ.pop_front());
            if (histQ.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (histQ[i] != patVec[WIDTH-1-i]) d++;
                end
                tolEff = (int'(tol) < MAX_ERR) ? int'(tol) : MAX_ERR;
                hit = (d <= tolEff);
            end
        end
        mFound = hit;
        mExact = hit && (d == 0);
        if (hit) mDist = d;
        if (hit && !ovl) histQ.delete();
        if (clr) begin
            mCountA = hit ? 1 : 0;
            mCountB = hit ? 1 : 0;
        end else if (hit) begin
            mCountA = (mCountA + 1 > (1 << CNT_A_W) - 1) ? (1 << CNT_A_W) - 1 : mCountA + 1;
            mCountB = (mCountB + 1 > (1 << CNT_B_W) - 1) ? (1 << CNT_B_W) - 1 : mCountB + 1;
        end
    endtask

    task automatic applyStimulus(input bit rstN, input bit v, input bit d, input bit o,
                                 input int t, input bit c);
        resetn = rstN; valid = v; data = d; ovl = o; tol = t[ERR_W-1:0]; clr = c;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== expected[31:0]) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".foundA"}, 32'(foundA), int'(mFound));
        checkValue({tag, ".exactA"}, 32'(exactA), int'(mExact));
        checkValue({tag, ".distA"},  32'(distA),  mDist);
        checkValue({tag, ".countA"}, 32'(countA), mCountA);
        checkValue({tag, ".foundB"}, 32'(foundB), int'(mFound));
        checkValue({tag, ".exactB"}, 32'(exactB), int'(mExact));
        checkValue({tag, ".distB"},  32'(distB),  mDist);
        checkValue({tag, ".countB"}, 32'(countB), mCountB);
    endtask

    task automatic sendBits(input logic [31:0] bits, input int n, input bit o, input int t,
                            input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b1, bits[i], o, t, 1'b0);
            checkOutput($sformatf("%s.b%0d", tag, n - i));
        end
    endtask

    task automatic doReset(input string tag);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 7, 1'b1);
        checkOutput({tag, ".reset"});
    endtask

    initial begin
        // Exact match, tolerant match at distance 2, rejected window at distance 3.
        addRow(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        addRow(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        addRow(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        addRow(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 0, 0, 1, 1, 0, 1);
        addRow(1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        addRow(0, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 0, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 2, 0, 1, 0, 2, 1);
        addRow(0, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 0, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 0, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        addRow(1, 1, 1, 1, 2, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].rstN, vecs[i].v, vecs[i].d, vecs[i].o, vecs[i].t, vecs[i].c);
            checkOutput(tag);
            checkValue({tag, ".tblFound"}, 32'(foundA), int'(vecs[i].eFound));
            checkValue({tag, ".tblExact"}, 32'(exactA), int'(vecs[i].eExact));
            checkValue({tag, ".tblDist"},  32'(distA),  vecs[i].eDist);
            checkValue({tag, ".tblCount"}, 32'(countA), vecs[i].eCount);
        end

        // Overlapping vs non-overlapping on 101001001 with tolerance 1.
        doReset("ovl1");
        sendBits(32'b101001001, 9, 1'b1, 1, "ovl1");
        checkValue("ovl1.count", 32'(countA), 2);
        checkValue("ovl1.dist", 32'(distA), 1);
        doReset("ovl0");
        sendBits(32'b101001001, 9, 1'b0, 1, "ovl0");
        checkValue("ovl0.count", 32'(countA), 1);
        checkValue("ovl0.dist", 32'(distA), 0);

        // Valid gaps with toggling data must not disturb the window.
        doReset("gap");
        sendBits(32'b101, 3, 1'b1, 0, "gap");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, i[0], 1'b1, 0, 1'b0);
            checkOutput($sformatf("gap.idle%0d", i));
        end
        sendBits(32'b001, 3, 1'b1, 0, "gap.tail");
        checkValue("gap.found", 32'(foundA), 1);
        checkValue("gap.count", 32'(countA), 1);

        // Tolerance request above MAX_ERR is clamped.
        doReset("clamp");
        sendBits(32'b110011, 6, 1'b1, 5, "clamp");
        checkValue("clamp.count", 32'(countA), 0);

        // Saturation of the narrow counter, clear alone, clear with a hit.
        doReset("sat");
        for (int h = 0; h < 4; h++) sendBits(32'b101001, 6, 1'b0, 0, $sformatf("sat%0d", h));
        checkValue("sat.countA", 32'(countA), 4);
        checkValue("sat.countB", 32'(countB), 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        checkOutput("clr.alone");
        checkValue("clr.alone.countB", 32'(countB), 0);
        sendBits(32'b10100, 5, 1'b0, 0, "clrhit");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        checkOutput("clrhit.last");
        checkValue("clrhit.countA", 32'(countA), 1);
        checkValue("clrhit.countB", 32'(countB), 1);

        // Reset in the middle of a partial pattern discards it.
        doReset("midrst");
        sendBits(32'b10100, 5, 1'b1, 0, "midrst.pre");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        checkOutput("midrst.reset");
        checkValue("midrst.found", 32'(foundA), 0);
        sendBits(32'b1, 1, 1'b1, 0, "midrst.one");
        checkValue("midrst.nohit", 32'(foundA), 0);
        doReset("midrst2");
        sendBits(32'b10100, 5, 1'b1, 0, "midrst2.pre");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        checkOutput("midrst2.reset");
        sendBits(32'b101001, 6, 1'b1, 0, "midrst2.fresh");
        checkValue("midrst2.found", 32'(foundA), 1);

        // Random traffic, including occasional resets, clears and mode changes.
        doReset("rnd");
        begin
            bit rOvl;
            int rTol;
            rOvl = 1'b1;
            rTol = 1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(15) == 0) rOvl = ~rOvl;
                if ($urandom_range(7) == 0) rTol = $urandom_range(7);
                applyStimulus($urandom_range(99) != 0, $urandom_range(3) != 0,
                              1'($urandom_range(1)), rOvl, rTol, $urandom_range(29) == 0);
                checkOutput($sformatf("rnd%0d", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
